uart_alu_interface: RTL and testbench

Byte-level sequencer between the UART receiver and the UART transmitter. Collects three consecutive received bytes (operand A, operand B, opcode), presents them to the combinational ALU, captures the ALU result, and hands it to the transmitter with a start/done handshake. Sits downstream of the receiver's `rx_done_tick` and data byte, and upstream of the transmitter.

---
 rtl/uart_alu_interface_pkg.sv | 31 +++
 rtl/uart_alu_interface_if.sv | 29 ++
 rtl/uart_alu_interface.sv | 101 ++++++++++
 tb/tb_uart_alu_interface.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_alu_interface_pkg.sv
// Shared definitions for the UART <-> ALU byte sequencer: widths, state
// encodings and the opcode constants also used by the ALU.
package uart_alu_interface_pkg;

    localparam int unsigned NB_DATA_DEF = 8;
    localparam int unsigned NB_OP_DEF   = 6;

    typedef enum logic [2:0] {
        ST_WAIT_A  = 3'd0,
        ST_WAIT_B  = 3'd1,
        ST_WAIT_OP = 3'd2,
        ST_CALC    = 3'd3,
        ST_SEND    = 3'd4,
        ST_WAIT_TX = 3'd5
    } state_t;

    localparam logic [NB_OP_DEF-1:0] OP_ADD = 6'h20;
    localparam logic [NB_OP_DEF-1:0] OP_SUB = 6'h22;
    localparam logic [NB_OP_DEF-1:0] OP_AND = 6'h24;
    localparam logic [NB_OP_DEF-1:0] OP_OR  = 6'h25;
    localparam logic [NB_OP_DEF-1:0] OP_XOR = 6'h26;
    localparam logic [NB_OP_DEF-1:0] OP_NOR = 6'h27;
    localparam logic [NB_OP_DEF-1:0] OP_SRA = 6'h03;
    localparam logic [NB_OP_DEF-1:0] OP_SRL = 6'h02;

    // States in which a received byte cannot be accepted
    function automatic logic is_busy(input state_t s);
        return (s == ST_CALC) || (s == ST_SEND) || (s == ST_WAIT_TX);
    endfunction

endpackage

// File: rtl/uart_alu_interface_if.sv
// Receiver/ALU/transmitter side signals of the sequencer, grouped as one bundle.
interface uart_alu_interface_if
    import uart_alu_interface_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF,
    parameter int unsigned NB_OP   = NB_OP_DEF
);
    logic [NB_DATA-1:0] i_rx_data;
    logic               i_rx_done;
    logic [NB_DATA-1:0] i_alu_result;
    logic               i_tx_done;
    logic [NB_DATA-1:0] o_alu_a;
    logic [NB_DATA-1:0] o_alu_b;
    logic [NB_OP-1:0]   o_alu_op;
    logic [NB_DATA-1:0] o_tx_data;
    logic               o_tx_start;
    logic               o_busy;
    logic               o_drop;

    modport master (
        input  i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        output o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_drop
    );

    modport slave (
        output i_rx_data, i_rx_done, i_alu_result, i_tx_done,
        input  o_alu_a, o_alu_b, o_alu_op, o_tx_data, o_tx_start, o_busy, o_drop
    );
endinterface

// File: rtl/uart_alu_interface.sv
// Collects operand A, operand B and opcode bytes from the UART receiver,
// latches the ALU result and launches it on the UART transmitter.
module uart_alu_interface
    import uart_alu_interface_pkg::*;
#(
    parameter int unsigned NB_DATA = NB_DATA_DEF,
    parameter int unsigned NB_OP   = NB_OP_DEF
)(
    input  logic                   i_clock,
    input  logic                   i_reset,
    uart_alu_interface_if.master   bus
);

    state_t             state_q, state_nxt;
    logic [NB_DATA-1:0] alu_a_q, alu_a_nxt;
    logic [NB_DATA-1:0] alu_b_q, alu_b_nxt;
    logic [NB_OP-1:0]   alu_op_q, alu_op_nxt;
    logic [NB_DATA-1:0] tx_data_q, tx_data_nxt;
    logic               tx_start_q, tx_start_nxt;
    logic               drop_q, drop_nxt;

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            state_q    <= ST_WAIT_A;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            alu_a_q    <= alu_a_nxt;
            alu_b_q    <= alu_b_nxt;
            alu_op_q   <= alu_op_nxt;
            tx_data_q  <= tx_data_nxt;
            tx_start_q <= tx_start_nxt;
            drop_q     <= drop_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        alu_a_nxt    = alu_a_q;
        alu_b_nxt    = alu_b_q;
        alu_op_nxt   = alu_op_q;
        tx_data_nxt  = tx_data_q;
        tx_start_nxt = 1'b0;
        drop_nxt     = 1'b0;

        case (state_q)
            ST_WAIT_A: begin
                if (bus.i_rx_done) begin
                    alu_a_nxt = bus.i_rx_data;
                    state_nxt = ST_WAIT_B;
                end
            end
            ST_WAIT_B: begin
                if (bus.i_rx_done) begin
                    alu_b_nxt = bus.i_rx_data;
                    state_nxt = ST_WAIT_OP;
                end
            end
            ST_WAIT_OP: begin
                if (bus.i_rx_done) begin
                    alu_op_nxt = bus.i_rx_data[NB_OP-1:0];
                    state_nxt  = ST_CALC;
                end
            end
            ST_CALC: begin
                tx_data_nxt  = bus.i_alu_result;
                tx_start_nxt = 1'b1;
                drop_nxt     = bus.i_rx_done;
                state_nxt    = ST_SEND;
            end
            ST_SEND: begin
                drop_nxt  = bus.i_rx_done;
                state_nxt = ST_WAIT_TX;
            end
            ST_WAIT_TX: begin
                // A byte coinciding with tx_done is still dropped
                drop_nxt = bus.i_rx_done;
                if (bus.i_tx_done) begin
                    state_nxt = ST_WAIT_A;
                end
            end
            default: begin
                state_nxt = ST_WAIT_A;
            end
        endcase
    end

    assign bus.o_alu_a    = alu_a_q;
    assign bus.o_alu_b    = alu_b_q;
    assign bus.o_alu_op   = alu_op_q;
    assign bus.o_tx_data  = tx_data_q;
    assign bus.o_tx_start = tx_start_q;
    assign bus.o_drop     = drop_q;
    assign bus.o_busy     = is_busy(state_q);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Directed plus randomized bench for the UART/ALU byte sequencer.
module tb_uart_alu_interface;
    import uart_alu_interface_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_assert = 0;
    int   n_fail   = 0;

    logic [7:0] m_a, m_b, m_tx;
    logic [5:0] m_op;

    always #5 clk = ~clk;

    uart_alu_interface_if #(.NB_DATA(8), .NB_OP(6)) bus ();

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6)) dut (
        .i_clock (clk),
        .i_reset (rst_n),
        .bus     (bus)
    );

    function automatic logic [7:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                           input logic [5:0] op);
        if (op == 6'h20) return a + b;
        if (op == 6'h22) return a - b;
        return 8'h00;
    endfunction

    assign bus.i_alu_result = alu_ref(bus.o_alu_a, bus.o_alu_b, bus.o_alu_op);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, ".a"},  32'(bus.o_alu_a),   32'(m_a));
        chk({tag, ".b"},  32'(bus.o_alu_b),   32'(m_b));
        chk({tag, ".op"}, 32'(bus.o_alu_op),  32'(m_op));
        chk({tag, ".tx"}, 32'(bus.o_tx_data), 32'(m_tx));
    endtask

    task automatic model_reset();
        m_a = 8'h00; m_b = 8'h00; m_op = 6'h00; m_tx = 8'h00;
    endtask

    task automatic check_idle_zero(input string tag);
        check_regs(tag);
        chk({tag, ".busy"},  32'(bus.o_busy),     32'd0);
        chk({tag, ".start"}, 32'(bus.o_tx_start), 32'd0);
        chk({tag, ".drop"},  32'(bus.o_drop),     32'd0);
    endtask

    // Sends n bytes of an A/B/opcode sequence; gap idle cycles between bytes
    task automatic send_seq(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input int unsigned gap, input int unsigned n);
        logic [7:0] bv [3];
        bv[0] = b0; bv[1] = b1; bv[2] = b2;
        for (int unsigned i = 0; i < n; i++) begin
            bus.i_rx_data = bv[i];
            bus.i_rx_done = 1'b1;
            @(negedge clk);
            if (i == 0) m_a = bv[0];
            else if (i == 1) m_b = bv[1];
            else m_op = bv[2][5:0];
            check_regs("byte");
            chk("byte.busy",  32'(bus.o_busy),     (i == 2) ? 32'd1 : 32'd0);
            chk("byte.start", 32'(bus.o_tx_start), 32'd0);
            chk("byte.drop",  32'(bus.o_drop),     32'd0);
            if (i == n - 1 || gap != 0) bus.i_rx_done = 1'b0;
            if (i < n - 1 && gap != 0) begin
                // stray tx_done pulses while collecting must be ignored
                for (int unsigned g = 0; g < gap; g++) begin
                    bus.i_tx_done = 1'($urandom_range(0, 1));
                    @(negedge clk);
                end
                bus.i_tx_done = 1'b0;
                check_regs("gap");
            end
        end
    endtask

    // Called right after the opcode byte; leaves the DUT waiting for tx_done
    task automatic finish_calc();
        int unsigned extra;
        int          pulses;
        m_tx = alu_ref(m_a, m_b, m_op);
        @(negedge clk);
        chk("calc.start", 32'(bus.o_tx_start), 32'd1);
        chk("calc.tx",    32'(bus.o_tx_data),  32'(m_tx));
        chk("calc.busy",  32'(bus.o_busy),     32'd1);
        @(negedge clk);
        chk("send.start", 32'(bus.o_tx_start), 32'd0);
        chk("send.busy",  32'(bus.o_busy),     32'd1);
        extra  = $urandom_range(0, 4);
        pulses = 0;
        for (int unsigned k = 0; k < extra; k++) begin
            @(negedge clk);
            if (bus.o_tx_start) pulses++;
        end
        chk("wait.start_pulses", 32'(pulses), 32'd0);
        chk("wait.busy", 32'(bus.o_busy), 32'd1);
    endtask

    task automatic release_tx();
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        chk("rel.busy", 32'(bus.o_busy), 32'd0);
        chk("rel.drop", 32'(bus.o_drop), 32'd0);
        check_regs("rel");
    endtask

    initial begin
        bus.i_rx_data = 8'h00;
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        model_reset();

        // 1: reset, then stray tx_done
        repeat (3) @(negedge clk);
        check_idle_zero("rst_held");
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_zero("rst_rel");
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_tx_done = 1'b0;
        @(negedge clk);
        check_idle_zero("stray_txdone");

        // 2: spaced bytes, ADD
        send_seq(8'h05, 8'h03, 8'h20, 10, 3);
        finish_calc();
        chk("t2.tx_const", 32'(bus.o_tx_data), 32'h08);
        release_tx();

        // 3: back-to-back bytes, SUB with upper opcode bits set
        send_seq(8'h10, 8'h04, 8'hE2, 0, 3);
        chk("t3.op_const", 32'(bus.o_alu_op), 32'h22);
        finish_calc();
        chk("t3.tx_const", 32'(bus.o_tx_data), 32'h0C);

        // 4: drops in WAIT_TX, including one coinciding with tx_done
        bus.i_rx_data = 8'h77;
        bus.i_rx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        chk("t4.drop1", 32'(bus.o_drop), 32'd1);
        chk("t4.busy1", 32'(bus.o_busy), 32'd1);
        check_regs("t4.d1");
        @(negedge clk);
        chk("t4.drop1_end", 32'(bus.o_drop), 32'd0);
        bus.i_rx_data = 8'h55;
        bus.i_rx_done = 1'b1;
        bus.i_tx_done = 1'b1;
        @(negedge clk);
        bus.i_rx_done = 1'b0;
        bus.i_tx_done = 1'b0;
        chk("t4.drop2", 32'(bus.o_drop), 32'd1);
        chk("t4.busy2", 32'(bus.o_busy), 32'd0);
        check_regs("t4.d2");
        @(negedge clk);
        chk("t4.drop2_end", 32'(bus.o_drop), 32'd0);
        check_regs("t4.after");
        send_seq(8'h01, 8'h01, 8'h20, 1, 3);
        finish_calc();
        chk("t4.tx_const", 32'(bus.o_tx_data), 32'h02);
        release_tx();

        // 5: asynchronous reset in WAIT_TX
        send_seq(8'h33, 8'h11, 8'h22, 2, 3);
        finish_calc();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_idle_zero("t5.async");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        send_seq(8'h40, 8'h02, 8'h20, 0, 3);
        finish_calc();
        release_tx();

        // 6: reset while waiting for the opcode
        send_seq(8'h09, 8'h06, 8'h00, 1, 2);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        @(negedge clk);
        check_idle_zero("t6.rst");
        rst_n = 1'b1;
        @(negedge clk);
        send_seq(8'hA0, 8'h0B, 8'h22, 1, 3);
        finish_calc();
        release_tx();

        // randomized transactions, next byte right after tx_done
        for (int t = 0; t < 25; t++) begin
            logic [7:0] ra, rb, rop;
            int unsigned sel;
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            sel = $urandom_range(0, 2);
            rop = 8'($urandom);
            if (sel == 0) rop[5:0] = 6'h20;
            else if (sel == 1) rop[5:0] = 6'h22;
            send_seq(ra, rb, rop, $urandom_range(0, 3), 3);
            finish_calc();
            release_tx();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
